// File: rtl/izz_pkg.sv
// izz_pkg: shared constants and FSM encoding for the izigzag channel scheduler.
package izz_pkg;

   localparam int IZZ_W    = 16;   // data width of one channel token
   localparam int IZZ_NCH  = 8;    // channel queues chuA..chuH
   localparam int IZZ_ROWS = 8;    // rows per 64-coefficient block

   // RUN forwards tokens; EOS silently drains the remaining end-of-stream tokens
   typedef enum logic {
      RUN = 1'b0,
      EOS = 1'b1
   } izzState_t;

endpackage

// File: rtl/izz_out_reg.sv
// izz_out_reg: 1-deep registered output stage of the scheduler stream.
// Holds one coefficient (d/e/last) with its valid flag and reports when the
// held token is blocked by downstream back-pressure.
module izz_out_reg
   import izz_pkg::*;
#(
   parameter int W = IZZ_W
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] loadD,
   input  logic         loadE,
   input  logic         loadLast,
   input  logic         outB,
   output logic [W-1:0] outD,
   output logic         outE,
   output logic         outLast,
   output logic         outV,
   output logic         stall
);

   logic [W-1:0] dReg;
   logic         eReg;
   logic         lastReg;
   logic         vReg;

   // A held token that downstream refuses blocks any new load.
   assign stall = vReg & outB;

   // Load a new token (also when the old one drains on the same edge),
   // otherwise drop valid once downstream has taken the held token.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dReg    <= '0;
         eReg    <= 1'b0;
         lastReg <= 1'b0;
         vReg    <= 1'b0;
      end else if (load) begin
         dReg    <= loadD;
         eReg    <= loadE;
         lastReg <= loadLast;
         vReg    <= 1'b1;
      end else if (vReg & !outB) begin
         vReg    <= 1'b0;
      end
   end

   assign outD    = dReg;
   assign outE    = eReg;
   assign outLast = lastReg;
   assign outV    = vReg;

endmodule

// File: rtl/izigzag_chan_sched.sv
// izigzag_chan_sched: ordered 8-to-1 scheduler draining channel queues A..H,
// one token per channel per row, 8 rows per 64-coefficient block.
// Optional macro IZZ_SCHED_BLKCNT_EN adds the blk_cnt completed-block counter.
module izigzag_chan_sched
   import izz_pkg::*;
#(
   parameter int W   = IZZ_W,
   parameter int NCH = IZZ_NCH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [NCH*W-1:0] in_d,
   input  logic [NCH-1:0]   in_e,
   input  logic [NCH-1:0]   in_v,
   output logic [NCH-1:0]   in_b,
   output logic [W-1:0]     out_d,
   output logic             out_e,
   output logic             out_v,
   input  logic             out_b,
   output logic             out_last,
   output logic [2:0]       sel,
   output logic             err
`ifdef IZZ_SCHED_BLKCNT_EN
   ,
   output logic [15:0]      blk_cnt
`endif
);

   localparam logic [2:0] LAST_SEL = 3'(NCH - 1);
   localparam logic [2:0] LAST_ROW = 3'(IZZ_ROWS - 1);

   izzState_t    stateReg;
   logic [2:0]   selReg;
   logic [2:0]   rowReg;
   logic         errReg;

   logic [W-1:0] chanD [NCH];
   logic [W-1:0] selD;
   logic         selE;
   logic         selV;
   logic         stall;
   logic         runAcc;
   logic         eosAcc;
   logic         loadLast;

   // Split the flat channel bus into per-channel words and build the
   // per-channel back-pressure: only the selected queue may advance.
   // During EOS draining the output stall is irrelevant, so the selected
   // queue is released regardless of downstream.
   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : gChan
         assign chanD[gi] = in_d[gi*W +: W];
         assign in_b[gi]  = !reset
                          | (selReg != 3'(gi))
                          | ((stateReg == RUN) & stall);
      end
   endgenerate

   assign selD = chanD[selReg];
   assign selE = in_e[selReg];
   assign selV = in_v[selReg];

   assign runAcc   = (stateReg == RUN) & selV & !stall;
   assign eosAcc   = (stateReg == EOS) & selV;
   assign loadLast = !selE & (rowReg == LAST_ROW) & (selReg == LAST_SEL);

   izz_out_reg #(
      .W (W)
   ) uOutReg (
      .clock    (clock),
      .reset    (reset),
      .load     (runAcc),
      .loadD    (selD),
      .loadE    (selE),
      .loadLast (loadLast),
      .outB     (out_b),
      .outD     (out_d),
      .outE     (out_e),
      .outLast  (out_last),
      .outV     (out_v),
      .stall    (stall)
   );

   // Scheduler FSM: advance channel/row counters on each consumed token,
   // handle end-of-stream alignment and flag protocol errors (sticky).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateReg <= RUN;
         selReg   <= 3'd0;
         rowReg   <= 3'd0;
         errReg   <= 1'b0;
      end else begin
         case (stateReg)
            RUN: begin
               if (runAcc) begin
                  if (!selE) begin
                     selReg <= selReg + 3'd1;
                     if (selReg == LAST_SEL) begin
                        rowReg <= rowReg + 3'd1;
                     end
                  end else begin
                     // EOS is only legal as the very first token of a block
                     if ((selReg != 3'd0) || (rowReg != 3'd0)) begin
                        errReg <= 1'b1;
                     end
                     if (selReg == LAST_SEL) begin
                        selReg <= 3'd0;
                        rowReg <= 3'd0;
                     end else begin
                        stateReg <= EOS;
                        selReg   <= selReg + 3'd1;
                     end
                  end
               end
            end
            EOS: begin
               if (eosAcc) begin
                  // the remaining channels must also carry end-of-stream
                  if (!selE) begin
                     errReg <= 1'b1;
                  end
                  if (selReg == LAST_SEL) begin
                     stateReg <= RUN;
                     selReg   <= 3'd0;
                     rowReg   <= 3'd0;
                  end else begin
                     selReg <= selReg + 3'd1;
                  end
               end
            end
            default: begin
               stateReg <= RUN;
            end
         endcase
      end
   end

   assign sel = selReg;
   assign err = errReg;

`ifdef IZZ_SCHED_BLKCNT_EN
   logic [15:0] blkCntReg;

   // Count blocks whose final coefficient has been taken by downstream.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         blkCntReg <= 16'd0;
      end else if (out_v & out_last & !out_b) begin
         blkCntReg <= blkCntReg + 16'd1;
      end
   end

   assign blk_cnt = blkCntReg;
`endif

endmodule

// File: tb/tb_izigzag_chan_sched.sv
// tb_izigzag_chan_sched: scoreboard bench for izigzag_chan_sched.
// Per-channel source queues feed the DUT; expected output tokens are queued
// when stimulus is issued and a monitor pops/compares on each transfer.
module tb_izigzag_chan_sched;

   logic         clock;
   logic         reset;
   logic [127:0] in_d;
   logic [7:0]   in_e;
   logic [7:0]   in_v;
   logic [7:0]   in_b;
   logic [15:0]  out_d;
   logic         out_e;
   logic         out_v;
   logic         out_b;
   logic         out_last;
   logic [2:0]   sel;
   logic         err;
`ifdef IZZ_SCHED_BLKCNT_EN
   logic [15:0]  blk_cnt;
`endif

   izigzag_chan_sched #(
      .W   (16),
      .NCH (8)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .in_d     (in_d),
      .in_e     (in_e),
      .in_v     (in_v),
      .in_b     (in_b),
      .out_d    (out_d),
      .out_e    (out_e),
      .out_v    (out_v),
      .out_b    (out_b),
      .out_last (out_last),
      .sel      (sel),
`ifdef IZZ_SCHED_BLKCNT_EN
      .blk_cnt  (blk_cnt),
`endif
      .err      (err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // source tokens {e, d} per channel; expected outputs {e, last, d}
   logic [16:0] src_q [8][$];
   logic [17:0] exp_q [$];
   logic [7:0]  hold_mask;
   logic [15:0] next_d;
   int          checks;
   int          fails;
   int          xfers;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic at_neg();
      @(negedge clock);
      #1;
   endtask

   function automatic logic srcs_empty();
      logic r;
      r = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (src_q[i].size() != 0) r = 1'b0;
      end
      return r;
   endfunction

   task automatic push_tok(input int ch, input logic e, input logic fwd, input logic last);
      src_q[ch].push_back({e, next_d});
      if (fwd) exp_q.push_back({e, last, next_d});
      next_d = next_d + 16'd1;
   endtask

   task automatic push_block();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            push_tok(c, 1'b0, 1'b1, (r == 7) && (c == 7));
         end
      end
   endtask

   task automatic wait_idle(input string name, input int maxcyc, output int ncyc);
      logic idle;
      ncyc = 0;
      idle = 1'b0;
      while (!idle && ncyc < maxcyc) begin
         at_neg();
         ncyc++;
         idle = (exp_q.size() == 0) && srcs_empty() && !out_v;
      end
      check(name, 32'(idle), 32'd1);
   endtask

   // Presents queue heads to the DUT and retires tokens it consumes.
   task automatic driver();
      in_v = '0;
      in_e = '0;
      in_d = '0;
      forever begin
         @(negedge clock);
         #2;
         for (int i = 0; i < 8; i++) begin
            if (src_q[i].size() != 0 && !hold_mask[i]) begin
               in_v[i]           = 1'b1;
               in_e[i]           = src_q[i][0][16];
               in_d[i*16 +: 16]  = src_q[i][0][15:0];
            end else begin
               in_v[i]           = 1'b0;
               in_e[i]           = 1'b0;
               in_d[i*16 +: 16]  = 16'h0;
            end
         end
         #1;
         for (int i = 0; i < 8; i++) begin
            if (in_v[i] && !in_b[i]) void'(src_q[i].pop_front());
         end
      end
   endtask

   // Compares every token downstream accepts against the scoreboard.
   task automatic monitor();
      logic [17:0] expv;
      forever begin
         @(negedge clock);
         #3;
         if (out_v && !out_b) begin
            xfers++;
            if (exp_q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL token: unexpected d=%h e=%b last=%b", out_d, out_e, out_last);
            end else begin
               expv = exp_q.pop_front();
               $display("xfer %0d d=%h e=%b last=%b", xfers, out_d, out_e, out_last);
               check("token", 32'({out_e, out_last, out_d}), 32'(expv));
            end
         end
      end
   endtask

   initial begin
      int n;
      int x0;
      logic [15:0] held;
      checks    = 0;
      fails     = 0;
      xfers     = 0;
      next_d    = 16'h0100;
      hold_mask = '0;
      reset     = 1'b0;
      out_b     = 1'b0;
      fork
         driver();
         monitor();
      join_none

      // reset state
      repeat (2) at_neg();
      check("rst_out_v", 32'(out_v), 32'd0);
      check("rst_out_d", 32'(out_d), 32'd0);
      check("rst_out_e", 32'(out_e), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_in_b", 32'(in_b), 32'hFF);
      reset = 1'b1;

      // two full blocks back to back at one token per clock
      push_block();
      push_block();
      wait_idle("stream_done", 400, n);
      check("throughput", 32'(n <= 132), 32'd1);
      check("sel_after_blocks", 32'(sel), 32'd0);

      // channel C absent for 5 cycles: output pauses after B
      hold_mask = 8'h04;
      x0 = xfers;
      push_block();
      repeat (5) at_neg();
      check("gap_xfers", 32'(xfers - x0), 32'd2);
      check("gap_sel", 32'(sel), 32'd2);
      check("gap_out_v", 32'(out_v), 32'd0);
      check("gap_in_b", 32'(in_b), 32'hFB);
      hold_mask = 8'h00;
      wait_idle("gap_done", 200, n);

      // downstream stall for 4 cycles mid-row
      push_block();
      n = 0;
      while (exp_q.size() > 61 && n < 50) begin
         at_neg();
         n++;
      end
      out_b = 1'b1;
      held  = out_d;
      for (int k = 0; k < 4; k++) begin
         at_neg();
         check("stall_v", 32'(out_v), 32'd1);
         check("stall_d", 32'(out_d), 32'(held));
         check("stall_in_b", 32'(in_b), 32'hFF);
      end
      out_b = 1'b0;
      wait_idle("stall_done", 200, n);

      // aligned end-of-stream: only channel A forwarded
      for (int c = 0; c < 8; c++) push_tok(c, 1'b1, c == 0, 1'b0);
      wait_idle("eos_done", 100, n);
      check("eos_err", 32'(err), 32'd0);
      check("eos_sel", 32'(sel), 32'd0);
      push_block();
      wait_idle("after_eos_done", 200, n);

      // misaligned end-of-stream on channel D, row 3, with a stray data token
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) push_tok(c, 1'b0, 1'b1, 1'b0);
      end
      for (int c = 0; c < 3; c++) push_tok(c, 1'b0, 1'b1, 1'b0);
      push_tok(3, 1'b1, 1'b1, 1'b0);
      push_tok(4, 1'b1, 1'b0, 1'b0);
      push_tok(5, 1'b0, 1'b0, 1'b0);
      push_tok(6, 1'b1, 1'b0, 1'b0);
      push_tok(7, 1'b1, 1'b0, 1'b0);
      wait_idle("mis_done", 200, n);
      check("mis_err", 32'(err), 32'd1);
      check("mis_sel", 32'(sel), 32'd0);
      push_block();
      wait_idle("mis_next_done", 200, n);
      check("mis_err_sticky", 32'(err), 32'd1);

      // reset in row 5 with a token held in the output register
      for (int k = 0; k < 43; k++) push_tok(k % 8, 1'b0, 1'b1, 1'b0);
      n = 0;
      while (!(exp_q.size() == 1 && out_v) && n < 100) begin
         at_neg();
         n++;
      end
      out_b = 1'b1;
      at_neg();
      check("prerst_held", 32'(out_v), 32'd1);
      #1;
      reset = 1'b0;
      #1;
      check("mrst_out_v", 32'(out_v), 32'd0);
      check("mrst_out_d", 32'(out_d), 32'd0);
      check("mrst_sel", 32'(sel), 32'd0);
      check("mrst_err", 32'(err), 32'd0);
      check("mrst_in_b", 32'(in_b), 32'hFF);
      exp_q.delete();
      for (int i = 0; i < 8; i++) src_q[i].delete();
      out_b = 1'b0;
      at_neg();
      reset = 1'b1;

      // three blocks after reset
      push_block();
      push_block();
      push_block();
      wait_idle("post_rst_done", 600, n);
`ifdef IZZ_SCHED_BLKCNT_EN
      check("blk_cnt", 32'(blk_cnt), 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
